core_issue_window: RTL and testbench
====================================

Name: core_issue_window

Overview:
- Parametrised successor to the per-slot cascaded TOY decoder.
- Holds up to DEPTH fetched TOY instructions in a circular window.
- Each cycle, issues in program order up to ISSUE_W single-cycle ALU ops (opcodes 1-7) onto parallel lanes.
- Hands memory, control and halt ops (0, 8-F) one at a time to the preempt unit via a valid/ready/done handshake.
- Tracks pending load destinations in a registered 16-bit scoreboard, so loads are non-blocking.

Parameters:
DEPTH, 4, window slots (power of two, >=2)
ISSUE_W, 2, ALU issue lanes (1..DEPTH)
PC_W, 8, program counter width

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-high reset
fetch_valid_i  input  1  fetch offers an instruction
fetch_ready_o  output  1  window accepts; transfer when valid&&ready
fetch_instr_i  input  16  instruction
fetch_pc_i  input  PC_W  its pc
alu_valid_o  output  ISSUE_W  lane k issues this cycle
alu_instr_o  output  16*ISSUE_W  lane k instruction
alu_pc_o  output  PC_W*ISSUE_W  lane k pc
pre_valid_o  output  1  preempt op offered
pre_ready_i  input  1  preempt unit accepts
pre_instr_o  output  16  preempt instruction
pre_pc_o  output  PC_W  its pc
pre_done_i  input  1  blocking preempt op completed
pre_flush_i  input  1  with pre_done_i: jump taken, discard window
ld_wb_valid_i  input  1  load data written to ARF
ld_wb_rd_i  input  4  load destination
dirty_o  output  16  scoreboard
halted_o  output  1  core halted

Behaviour:
- Reset: window empty (head=tail=count=0), dirty=0, state RUN; all outputs 0.
- fetch_ready_o = (count<DEPTH) && state!=HALTED && !rst_i. No same-cycle free-slot reuse.
- One fetch per cycle is written at tail.
- Sources:
  - ops 1-6: rs, rt
  - ops 9, C, D, E: rd
  - op A: rt
  - op B: rd, rt
  - ops 0, 7, 8, F: none
- Destinations: ops 1-8, A, F write rd. R0 is never marked dirty.
- Hazard: a slot is blocked if any source or its destination is set in registered dirty. The destination check gives WAW protection against in-flight loads.
- ALU issue, state RUN:
  - Scan from head over consecutive ALU-class slots.
  - Issue the slot if it is unblocked and no source equals the nonzero rd of an earlier slot issued in the same cycle.
  - Stop at the first non-issuable slot, the first non-ALU slot, or after ISSUE_W slots.
  - Lanes are filled from lane 0. Head advances and count decrements by the number issued.
- Preempt issue:
  - Only when the head is preempt-class and unblocked, state is RUN, and no ALU op issues this cycle.
  - Drives pre_valid_o and moves to WAIT_ACC.
  - In WAIT_ACC, pre_valid_o, pre_instr_o and pre_pc_o are held stable until pre_ready_i.
- On acceptance:
  - ops 8, A: set dirty[rd] if rd≠0, pop head, go to RUN (non-blocking).
  - ops 9, B-F: pop head, go to WAIT_DONE.
  - op 0: not offered unless dirty==0. On acceptance go to HALTED.
- WAIT_DONE:
  - pre_done_i returns to RUN.
  - If pre_flush_i is also high, clear the window (count=0, head=tail) and drop any same-cycle fetch. dirty is preserved.
- HALTED: halted_o=1, no issue or fetch, until rst_i.
- ld_wb_valid_i clears dirty[ld_wb_rd_i] at end of cycle. The clear is visible to hazard checks the next cycle.
- A set and a clear for the same register in one cycle cannot occur, because that rd is blocked while dirty. Set wins if violated.
- Pointers wrap modulo DEPTH. count spans 0..DEPTH.
- Reset mid-handshake abandons the in-flight op and empties the window.

Optional Feature:
CORE_ISSUE_STATS_EN:
- When defined, adds output ports stat_issued_o (32) and stat_stall_o (32).
- stat_issued_o counts ALU and preempt issues.
- stat_stall_o counts cycles with count>0, state RUN, and nothing issued.
- Both counters saturate and are cleared by reset.
- When undefined, these ports and counters are absent.

Test Plan:
- Fetch 1123, 2456, 3789 (ISSUE_W=2, no hazards) -> cycle after fill: lanes 0,1 issue 1123 and 2456; next cycle lane 0 issues 3789.
- Fetch 1312 then 2431 -> only 1312 issues in the first cycle (R3 dependence); 2431 issues the next cycle.
- Fetch 8510 then 1655; pre_ready_i=1 -> dirty_o=0x0020; 1655 blocked until ld_wb_valid_i with rd=5; issues the cycle after the clear.
- Fetch C310, 1111, 1222; accept; pre_done_i with pre_flush_i=1 -> window empty, 1111/1222 never issue, alu_valid_o=0.
- Fetch 8410, 0000 -> halt not offered while dirty_o=0x0010; after writeback pre_valid_o with 0000; on acceptance halted_o=1 and fetch_ready_o=0.
- Hold pre_ready_i=0 for 5 cycles on 9A20 -> pre_valid_o and pre_instr_o stable for all 5; assert rst_i -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/core_issue_window_if.sv
// core_issue_window_if: fetch, ALU lane, preempt handshake, load writeback and status
// signals of the issue window. The window uses the slave view; its environment uses master.
interface core_issue_window_if #(
  parameter int unsigned ISSUE_W = 2,
  parameter int unsigned PC_W    = 8
);
  logic                      fetch_valid_i;
  logic                      fetch_ready_o;
  logic [15:0]               fetch_instr_i;
  logic [PC_W-1:0]           fetch_pc_i;
  logic [ISSUE_W-1:0]        alu_valid_o;
  logic [16*ISSUE_W-1:0]     alu_instr_o;
  logic [PC_W*ISSUE_W-1:0]   alu_pc_o;
  logic                      pre_valid_o;
  logic                      pre_ready_i;
  logic [15:0]               pre_instr_o;
  logic [PC_W-1:0]           pre_pc_o;
  logic                      pre_done_i;
  logic                      pre_flush_i;
  logic                      ld_wb_valid_i;
  logic [3:0]                ld_wb_rd_i;
  logic [15:0]               dirty_o;
  logic                      halted_o;

  modport slave (
    input  fetch_valid_i, fetch_instr_i, fetch_pc_i, pre_ready_i, pre_done_i, pre_flush_i,
           ld_wb_valid_i, ld_wb_rd_i,
    output fetch_ready_o, alu_valid_o, alu_instr_o, alu_pc_o, pre_valid_o, pre_instr_o,
           pre_pc_o, dirty_o, halted_o
  );

  modport master (
    output fetch_valid_i, fetch_instr_i, fetch_pc_i, pre_ready_i, pre_done_i, pre_flush_i,
           ld_wb_valid_i, ld_wb_rd_i,
    input  fetch_ready_o, alu_valid_o, alu_instr_o, alu_pc_o, pre_valid_o, pre_instr_o,
           pre_pc_o, dirty_o, halted_o
  );
endinterface

// File: rtl/core_issue_window.sv
// core_issue_window: circular window of fetched TOY instructions. Issues up to ISSUE_W
// in-order ALU ops (1-7) per cycle and hands memory/control/halt ops (0, 8-F) one at a
// time to the preempt unit. Pending load destinations are tracked in a 16-bit scoreboard.
// Optional build macro CORE_ISSUE_STATS_EN adds saturating issue/stall counters.
module core_issue_window #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ISSUE_W = 2,
  parameter int unsigned PC_W    = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
`ifdef CORE_ISSUE_STATS_EN
  output logic [31:0]          stat_issued_o,
  output logic [31:0]          stat_stall_o,
`endif
  core_issue_window_if.slave   bus
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {StRun, StWaitAcc, StWaitDone, StHalted} state_e;

  // Instruction field helpers: [15:12] op, [11:8] rd, [7:4] rs, [3:0] rt.
  function automatic logic is_alu(input logic [3:0] op);
    return (op >= 4'h1) && (op <= 4'h7);
  endfunction

  function automatic logic [15:0] src_mask(input logic [15:0] ins);
    logic [15:0] m;
    m = '0;
    case (ins[15:12])
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: m = (16'h1 << ins[7:4]) | (16'h1 << ins[3:0]);
      4'h9, 4'hC, 4'hD, 4'hE:             m = 16'h1 << ins[11:8];
      4'hA:                               m = 16'h1 << ins[3:0];
      4'hB:                               m = (16'h1 << ins[11:8]) | (16'h1 << ins[3:0]);
      default:                            m = '0;
    endcase
    return m;
  endfunction

  function automatic logic [15:0] dst_mask(input logic [15:0] ins);
    logic [15:0] m;
    m = '0;
    case (ins[15:12])
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hA, 4'hF: m = 16'h1 << ins[11:8];
      default:                                                    m = '0;
    endcase
    return m;
  endfunction

  // Destination is checked too so a younger write cannot overtake an in-flight load.
  function automatic logic hazard(input logic [15:0] ins, input logic [15:0] dirty);
    return |((src_mask(ins) | dst_mask(ins)) & dirty);
  endfunction

  logic [15:0]         instr_q [DEPTH];
  logic [PC_W-1:0]     pc_q    [DEPTH];
  logic [PtrW-1:0]     head_q, tail_q;
  logic [CntW-1:0]     count_q;
  logic [15:0]         dirty_q, dirty_d;
  state_e              state_q;
  logic                pre_valid_q;
  logic [15:0]         pre_instr_q;
  logic [PC_W-1:0]     pre_pc_q;

  logic                issue_en, fetch_ready, push, accept, flush, pre_cand;
  logic [15:0]         head_instr;
  logic [CntW-1:0]     n_alu, pop;
  logic [ISSUE_W-1:0]  alu_valid;
  logic [16*ISSUE_W-1:0]   alu_instr;
  logic [PC_W*ISSUE_W-1:0] alu_pc;

  assign issue_en    = (state_q == StRun) && !rst_i;
  assign fetch_ready = (count_q < CntW'(DEPTH)) && (state_q != StHalted) && !rst_i;
  assign push        = bus.fetch_valid_i && fetch_ready;
  assign accept      = (state_q == StWaitAcc) && bus.pre_ready_i;
  assign flush       = (state_q == StWaitDone) && bus.pre_done_i && bus.pre_flush_i;
  assign head_instr  = instr_q[head_q];
  assign pop         = n_alu + CntW'(accept);

  // In-order ALU scan from head; stops at the first slot that cannot issue.
  always_comb begin
    logic            stop;
    logic [15:0]     issued_rd;
    logic [PtrW-1:0] idx;
    logic [15:0]     ins;
    alu_valid = '0;
    alu_instr = '0;
    alu_pc    = '0;
    n_alu     = '0;
    stop      = 1'b0;
    issued_rd = '0;
    idx       = '0;
    ins       = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      idx = head_q + PtrW'(k);
      ins = instr_q[idx];
      if (!stop && issue_en && (k < int'(count_q)) && is_alu(ins[15:12]) &&
          !hazard(ins, dirty_q) && ((src_mask(ins) & issued_rd) == 16'h0)) begin
        alu_valid[k]               = 1'b1;
        alu_instr[16*k +: 16]      = ins;
        alu_pc[PC_W*k +: PC_W]     = pc_q[idx];
        n_alu                      = n_alu + CntW'(1);
        if (ins[11:8] != 4'h0) issued_rd = issued_rd | dst_mask(ins);
      end else begin
        stop = 1'b1;
      end
    end
  end

  // Head may go to the preempt unit only when no ALU op issues; halt waits for a clean scoreboard.
  always_comb begin
    pre_cand = issue_en && (n_alu == '0) && (count_q != '0) && !is_alu(head_instr[15:12]) &&
               !hazard(head_instr, dirty_q) &&
               ((head_instr[15:12] != 4'h0) || (dirty_q == 16'h0));
  end

  // Scoreboard next state: writeback clears, accepted load sets (set wins), R0 never dirty.
  always_comb begin
    dirty_d = dirty_q;
    if (bus.ld_wb_valid_i) dirty_d[bus.ld_wb_rd_i] = 1'b0;
    if (accept && ((pre_instr_q[15:12] == 4'h8) || (pre_instr_q[15:12] == 4'hA)) &&
        (pre_instr_q[11:8] != 4'h0)) begin
      dirty_d[pre_instr_q[11:8]] = 1'b1;
    end
    dirty_d[0] = 1'b0;
  end

  // Slot storage; contents need no reset because occupancy is tracked by count.
  always_ff @(posedge clk_i) begin
    if (push && !flush) begin
      instr_q[tail_q] <= bus.fetch_instr_i;
      pc_q[tail_q]    <= bus.fetch_pc_i;
    end
  end

  // Window pointers, occupancy and scoreboard.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      dirty_q <= '0;
    end else begin
      dirty_q <= dirty_d;
      if (flush) begin
        head_q  <= tail_q;
        count_q <= '0;
      end else begin
        head_q  <= head_q + PtrW'(pop);
        tail_q  <= tail_q + PtrW'(push);
        count_q <= count_q + CntW'(push) - pop;
      end
    end
  end

  // Preempt handshake FSM with registered offer held stable until accepted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StRun;
      pre_valid_q <= 1'b0;
      pre_instr_q <= '0;
      pre_pc_q    <= '0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (pre_cand) begin
            state_q     <= StWaitAcc;
            pre_valid_q <= 1'b1;
            pre_instr_q <= head_instr;
            pre_pc_q    <= pc_q[head_q];
          end
        end
        StWaitAcc: begin
          if (bus.pre_ready_i) begin
            pre_valid_q <= 1'b0;
            pre_instr_q <= '0;
            pre_pc_q    <= '0;
            case (pre_instr_q[15:12])
              4'h8, 4'hA: state_q <= StRun;
              4'h0:       state_q <= StHalted;
              default:    state_q <= StWaitDone;
            endcase
          end
        end
        StWaitDone: begin
          if (bus.pre_done_i) state_q <= StRun;
        end
        StHalted: state_q <= StHalted;
        default:  state_q <= StRun;
      endcase
    end
  end

  assign bus.fetch_ready_o = fetch_ready;
  assign bus.alu_valid_o   = alu_valid;
  assign bus.alu_instr_o   = alu_instr;
  assign bus.alu_pc_o      = alu_pc;
  assign bus.pre_valid_o   = pre_valid_q;
  assign bus.pre_instr_o   = pre_instr_q;
  assign bus.pre_pc_o      = pre_pc_q;
  assign bus.dirty_o       = dirty_q;
  assign bus.halted_o      = (state_q == StHalted);

`ifdef CORE_ISSUE_STATS_EN
  logic [31:0] stat_issued_q, stat_stall_q;
  logic [32:0] issued_sum;
  logic        stall;

  // Issue count includes accepted preempt ops; stall means occupied, running, nothing moving.
  always_comb begin
    issued_sum = {1'b0, stat_issued_q} + 33'(n_alu) + 33'(accept);
    stall      = (count_q != '0) && issue_en && (n_alu == '0) && !pre_cand;
  end

  // Saturating statistics counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_issued_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      stat_issued_q <= issued_sum[32] ? 32'hFFFF_FFFF : issued_sum[31:0];
      if (stall && (stat_stall_q != 32'hFFFF_FFFF)) stat_stall_q <= stat_stall_q + 32'd1;
    end
  end

  assign stat_issued_o = stat_issued_q;
  assign stat_stall_o  = stat_stall_q;
`endif

endmodule

// File: tb/tb_core_issue_window.sv
// tb_core_issue_window: directed test of core_issue_window with default parameters
// (DEPTH=4, ISSUE_W=2, PC_W=8).
module tb_core_issue_window;
  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  core_issue_window_if #(.ISSUE_W(2), .PC_W(8)) bus ();

`ifdef CORE_ISSUE_STATS_EN
  logic [31:0] stat_issued, stat_stall;
`endif

  core_issue_window #(.DEPTH(4), .ISSUE_W(2), .PC_W(8)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
`ifdef CORE_ISSUE_STATS_EN
    .stat_issued_o (stat_issued),
    .stat_stall_o  (stat_stall),
`endif
    .bus           (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_fetch(input logic v, input logic [15:0] ins, input logic [7:0] pc);
    bus.fetch_valid_i = v;
    bus.fetch_instr_i = ins;
    bus.fetch_pc_i    = pc;
  endtask

  initial begin
    rst = 1'b1;
    set_fetch(1'b0, 16'h0, 8'h0);
    bus.pre_ready_i   = 1'b0;
    bus.pre_done_i    = 1'b0;
    bus.pre_flush_i   = 1'b0;
    bus.ld_wb_valid_i = 1'b0;
    bus.ld_wb_rd_i    = 4'h0;
    tick();
    tick();

    // Reset state
    check("rst_fetch_ready", bus.fetch_ready_o, 0);
    check("rst_alu_valid", bus.alu_valid_o, 0);
    check("rst_alu_instr", bus.alu_instr_o, 0);
    check("rst_pre_valid", bus.pre_valid_o, 0);
    check("rst_dirty", bus.dirty_o, 0);
    check("rst_halted", bus.halted_o, 0);
    rst = 1'b0;
    #1;
    check("post_rst_fetch_ready", bus.fetch_ready_o, 1);

    // Dual issue: park behind C000 while four ALU ops fill the window (wraps slot 0)
    set_fetch(1'b1, 16'hC000, 8'h40);
    tick();
    set_fetch(1'b1, 16'h1123, 8'h41);
    tick();
    check("c000_pre_valid", bus.pre_valid_o, 1);
    check("c000_pre_instr", bus.pre_instr_o, 16'hC000);
    check("c000_pre_pc", bus.pre_pc_o, 8'h40);
    check("wait_acc_no_alu", bus.alu_valid_o, 0);
    set_fetch(1'b1, 16'h2456, 8'h42);
    bus.pre_ready_i = 1'b1;
    tick();
    bus.pre_ready_i = 1'b0;
    check("c000_accepted", bus.pre_valid_o, 0);
    set_fetch(1'b1, 16'h3789, 8'h43);
    tick();
    check("ready_at_3", bus.fetch_ready_o, 1);
    set_fetch(1'b1, 16'h7F00, 8'h44);
    tick();
    set_fetch(1'b0, 16'h0, 8'h0);
    check("full_not_ready", bus.fetch_ready_o, 0);
    check("wait_done_no_alu", bus.alu_valid_o, 0);
    bus.pre_done_i = 1'b1;
    tick();
    bus.pre_done_i = 1'b0;
    check("dual1_valid", bus.alu_valid_o, 2'b11);
    check("dual1_instr", bus.alu_instr_o, 32'h2456_1123);
    check("dual1_pc", bus.alu_pc_o, 16'h4241);
    tick();
    check("dual2_valid", bus.alu_valid_o, 2'b11);
    check("dual2_instr", bus.alu_instr_o, 32'h7F00_3789);
    check("dual2_pc", bus.alu_pc_o, 16'h4443);
    tick();
    check("empty_no_alu", bus.alu_valid_o, 0);
    check("empty_ready", bus.fetch_ready_o, 1);

    // Same-cycle RAW: 2431 reads R3 written by 1312
    set_fetch(1'b1, 16'hC000, 8'h50);
    tick();
    set_fetch(1'b1, 16'h1312, 8'h51);
    tick();
    set_fetch(1'b1, 16'h2431, 8'h52);
    bus.pre_ready_i = 1'b1;
    tick();
    set_fetch(1'b0, 16'h0, 8'h0);
    bus.pre_ready_i = 1'b0;
    bus.pre_done_i  = 1'b1;
    tick();
    bus.pre_done_i = 1'b0;
    check("raw1_valid", bus.alu_valid_o, 2'b01);
    check("raw1_instr", bus.alu_instr_o, 32'h0000_1312);
    check("raw1_pc", bus.alu_pc_o, 16'h0051);
    tick();
    check("raw2_valid", bus.alu_valid_o, 2'b01);
    check("raw2_instr", bus.alu_instr_o, 32'h0000_2431);
    tick();

    // Non-blocking load 8510; 1655 waits on R5 until writeback
    set_fetch(1'b1, 16'h8510, 8'h60);
    tick();
    set_fetch(1'b1, 16'h1655, 8'h61);
    tick();
    set_fetch(1'b0, 16'h0, 8'h0);
    check("ld_pre_instr", bus.pre_instr_o, 16'h8510);
    bus.pre_ready_i = 1'b1;
    tick();
    bus.pre_ready_i = 1'b0;
    check("ld_dirty_set", bus.dirty_o, 16'h0020);
    check("ld_blocked1", bus.alu_valid_o, 0);
    tick();
    check("ld_blocked2", bus.alu_valid_o, 0);
    bus.ld_wb_valid_i = 1'b1;
    bus.ld_wb_rd_i    = 4'h5;
    #1;
    check("ld_wb_same_cycle", bus.alu_valid_o, 0);
    tick();
    bus.ld_wb_valid_i = 1'b0;
    check("ld_dirty_clear", bus.dirty_o, 0);
    check("ld_unblocked_valid", bus.alu_valid_o, 2'b01);
    check("ld_unblocked_instr", bus.alu_instr_o, 32'h0000_1655);
    tick();

    // Taken jump flushes 1111/1222 and drops the same-cycle fetch 1333
    set_fetch(1'b1, 16'hC310, 8'h70);
    tick();
    set_fetch(1'b1, 16'h1111, 8'h71);
    tick();
    set_fetch(1'b1, 16'h1222, 8'h72);
    bus.pre_ready_i = 1'b1;
    tick();
    bus.pre_ready_i = 1'b0;
    set_fetch(1'b1, 16'h1333, 8'h73);
    bus.pre_done_i  = 1'b1;
    bus.pre_flush_i = 1'b1;
    tick();
    set_fetch(1'b0, 16'h0, 8'h0);
    bus.pre_done_i  = 1'b0;
    bus.pre_flush_i = 1'b0;
    check("flush_no_alu1", bus.alu_valid_o, 0);
    check("flush_no_pre", bus.pre_valid_o, 0);
    tick();
    check("flush_no_alu2", bus.alu_valid_o, 0);

    // Load 8E10 dirties R14, then 9A20 offer held for 5 cycles, then mid-handshake reset
    set_fetch(1'b1, 16'h8E10, 8'h80);
    tick();
    set_fetch(1'b1, 16'h9A20, 8'h81);
    tick();
    set_fetch(1'b0, 16'h0, 8'h0);
    bus.pre_ready_i = 1'b1;
    tick();
    bus.pre_ready_i = 1'b0;
    tick();
    check("hold_dirty", bus.dirty_o, 16'h4000);
    for (int i = 0; i < 5; i++) begin
      check("hold_pre_valid", bus.pre_valid_o, 1);
      check("hold_pre_instr", bus.pre_instr_o, 16'h9A20);
      check("hold_pre_pc", bus.pre_pc_o, 8'h81);
      tick();
    end
    rst = 1'b1;
    tick();
    check("mid_rst_fetch_ready", bus.fetch_ready_o, 0);
    check("mid_rst_pre_valid", bus.pre_valid_o, 0);
    check("mid_rst_pre_instr", bus.pre_instr_o, 0);
    check("mid_rst_pre_pc", bus.pre_pc_o, 0);
    check("mid_rst_alu_valid", bus.alu_valid_o, 0);
    check("mid_rst_dirty", bus.dirty_o, 0);
    check("mid_rst_halted", bus.halted_o, 0);
    rst = 1'b0;
    #1;

    // Halt waits for a clean scoreboard
    set_fetch(1'b1, 16'h8410, 8'h90);
    tick();
    set_fetch(1'b1, 16'h0000, 8'h91);
    tick();
    set_fetch(1'b0, 16'h0, 8'h0);
    bus.pre_ready_i = 1'b1;
    tick();
    bus.pre_ready_i = 1'b0;
    check("halt_dirty", bus.dirty_o, 16'h0010);
    tick();
    check("halt_not_offered1", bus.pre_valid_o, 0);
    tick();
    check("halt_not_offered2", bus.pre_valid_o, 0);
    bus.ld_wb_valid_i = 1'b1;
    bus.ld_wb_rd_i    = 4'h4;
    tick();
    bus.ld_wb_valid_i = 1'b0;
    check("halt_dirty_clear", bus.dirty_o, 0);
    tick();
    check("halt_offered", bus.pre_valid_o, 1);
    check("halt_pre_instr", bus.pre_instr_o, 16'h0000);
    check("halt_pre_pc", bus.pre_pc_o, 8'h91);
    check("halt_not_yet", bus.halted_o, 0);
    bus.pre_ready_i = 1'b1;
    tick();
    bus.pre_ready_i = 1'b0;
    set_fetch(1'b1, 16'h1123, 8'hA0);
    #1;
    check("halted", bus.halted_o, 1);
    check("halted_fetch_ready", bus.fetch_ready_o, 0);
    check("halted_pre_valid", bus.pre_valid_o, 0);
    tick();
    check("halted_stays", bus.halted_o, 1);
    check("halted_no_alu", bus.alu_valid_o, 0);
    set_fetch(1'b0, 16'h0, 8'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
